mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single RAM port between the instruction-fetch requester and the load/store requester. Accepts one request at a time via a req/gnt handshake, drives the RAM command for one cycle, waits the fixed RAM read latency, and returns read data or write completion to the winner. It sits between the core's fetch and LSU paths and the external RAM interface, replacing the direct pc-to-ReadAddr hookup.

## Interface
Parameters:
- MEM_LAT, 1, cycles from the ReadEnable cycle to ReadData valid; legal range 1..15.
- STARVE_MAX, 4, consecutive LSU wins allowed while if_req is pending before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  64  fetch byte address; 4-byte aligned.
- if_gnt  out  1  one-cycle pulse; fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  instruction word.
- ls_req  in  1  load/store request; fields held stable until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  64  load/store byte address.
- ls_wdata  in  64  store data.
- ls_wmask  in  64  store bit mask.
- ls_gnt  out  1  one-cycle pulse; LSU request accepted.
- ls_done  out  1  one-cycle pulse; load data valid or store complete.
- ls_rdata  out  64  load data; 0 on store completion.
- ReadData  in  64  RAM read data.
- ReadEnable, WriteEnable  out  1  RAM command strobes.
- ReadAddr, WriteAddr  out  64  RAM addresses.
- WriteMask, WriteData  out  64  RAM store mask and data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Encodings are `ARB_IDLE=0`, `ARB_ISSUE=1`, `ARB_WAIT=2`, `ARB_RESP=3`.
- **IDLE / RESP (arbitrating states):**
  - If any request is pending, pick a winner and pulse its gnt combinationally.
  - Latch requester ID, addr, we, wdata, and wmask, then go to ISSUE. Otherwise go to IDLE.
- **Priority:** LSU wins over fetch, except when starve_cnt == STARVE_MAX; then fetch wins.
- **starve_cnt:**
  - Increments when LSU wins while if_req=1.
  - Clears when fetch wins or if_req=0.
  - Saturates at STARVE_MAX.
- **ISSUE (exactly 1 cycle):**
  - ReadEnable = ~we, WriteEnable = we.
  - ReadAddr = WriteAddr = latched addr; WriteData/WriteMask = latched values.
  - Load lat_cnt = MEM_LAT-1 and go to WAIT.
- **WAIT:**
  - Decrement lat_cnt each cycle.
  - When lat_cnt==0, capture ReadData into rdata_q and go to RESP.
- **RESP:** pulse if_rvalid or ls_done for the latched requester.
  - Fetch: if_rdata = addr[2] ? rdata_q[63:32] : rdata_q[31:0].
  - Load: ls_rdata = rdata_q. Store: ls_rdata = 0.
- All RAM outputs are 0 outside ISSUE. gnt is never asserted in ISSUE or WAIT.
- Simultaneous if_req and ls_req: exactly one gnt. The loser keeps req high and is served at a later arbitrating state.
- Reset mid-operation:
  - FSM returns to IDLE and in-flight requests are dropped.
  - No rvalid/done is produced for dropped requests.
  - The requester must re-issue.

## Timing
- Reset values: all outputs 0, FSM IDLE, starve_cnt 0, lat_cnt 0, rdata_q 0.
- Request accepted (gnt) in cycle T. ISSUE at T+1. ReadData sampled at T+1+MEM_LAT. rvalid/done at T+2+MEM_LAT.
- Back-to-back: a new gnt may occur in the RESP cycle, so sustained throughput is one access per MEM_LAT+2 cycles.
- Stores follow identical timing. ls_done marks completion; ReadData is ignored.

## Structure
- Bus widths come from the shared defines.v (`ADDR_BUS`, `DATA_BUS`, `INST_BUS`). Add the `ARB_*` state encodings there.
- One sub-module, mem_arb_pick: combinational winner selection plus the starve_cnt register.
- The FSM, latency counter, and request latch live in mem_port_arbiter.

## Test plan
- Fetch only, MEM_LAT=1:
  - Stimulus: if_req with if_addr=0x80000004, ReadData=0x11112222_33334444.
  - Required: if_gnt at T, ReadEnable and ReadAddr=0x80000004 at T+1, if_rvalid at T+3 with if_rdata=0x11112222.
- Load vs fetch collision:
  - Stimulus: both req in the same cycle.
  - Required: ls_gnt only. Fetch is granted in the ls_done cycle (RESP) and has zero RAM activity until its ISSUE.
- Store, MEM_LAT=3:
  - Stimulus: ls_we=1, addr 0x100, wdata 0xDEADBEEF, mask 0xFFFFFFFF.
  - Required: WriteEnable=1 for exactly one cycle with matching fields; ls_done at T+5 with ls_rdata=0.
- Starvation, STARVE_MAX=2:
  - Stimulus: ls_req held high, if_req held high.
  - Required: grant order LS, LS, IF, LS, LS, IF.
- Reset during WAIT:
  - Stimulus: drive rst=0 while in WAIT.
  - Required: all outputs 0 immediately (asynchronous); after release, no if_rvalid/ls_done until a new gnt.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, FSM encodings and the latched request payload for mem_port_arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_BUS = 64;
    localparam int unsigned DATA_BUS = 64;
    localparam int unsigned INST_BUS = 32;
    localparam int unsigned LAT_W    = 4;
    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic                is_ls;
        logic                we;
        logic [ADDR_BUS-1:0] addr;
        logic [DATA_BUS-1:0] wdata;
        logic [DATA_BUS-1:0] wmask;
    } arb_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and LSU with a starvation counter that forces fetch through.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic if_req,
    input  logic ls_req,
    output logic pick_if_c,
    output logic pick_ls_c
);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic                force_if;

    // LSU normally wins; fetch wins once it has been passed over STARVE_MAX times in a row
    always_comb begin
        force_if  = (starve_q == STARVE_W'(STARVE_MAX));
        pick_if_c = arb_en & if_req & (~ls_req | force_if);
        pick_ls_c = arb_en & ls_req & ~pick_if_c;
        starve_d  = starve_q;
        if (!if_req || pick_if_c) begin
            starve_d = '0;
        end else if (pick_ls_c && (starve_q < STARVE_W'(STARVE_MAX))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single RAM port between instruction fetch and load/store, one access at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_BUS-1:0] if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [INST_BUS-1:0] if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_BUS-1:0] ls_addr,
    input  logic [DATA_BUS-1:0] ls_wdata,
    input  logic [DATA_BUS-1:0] ls_wmask,
    output logic                ls_gnt,
    output logic                ls_done,
    output logic [DATA_BUS-1:0] ls_rdata,
    input  logic [DATA_BUS-1:0] ReadData,
    output logic                ReadEnable,
    output logic                WriteEnable,
    output logic [ADDR_BUS-1:0] ReadAddr,
    output logic [ADDR_BUS-1:0] WriteAddr,
    output logic [DATA_BUS-1:0] WriteMask,
    output logic [DATA_BUS-1:0] WriteData
);

    arb_state_e          state_q;
    arb_state_e          state_d;
    arb_req_t            req_q;
    arb_req_t            req_d;
    logic [LAT_W-1:0]    lat_q;
    logic [LAT_W-1:0]    lat_d;
    logic [DATA_BUS-1:0] rdata_q;
    logic [DATA_BUS-1:0] rdata_d;
    logic                arb_en;
    logic                pick_if_c;
    logic                pick_ls_c;

    // Grants only happen in arbitrating states and never while reset is held
    assign arb_en = rst & ((state_q == ARB_IDLE) | (state_q == ARB_RESP));

    mem_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .arb_en   (arb_en),
        .if_req   (if_req),
        .ls_req   (ls_req),
        .pick_if_c(pick_if_c),
        .pick_ls_c(pick_ls_c)
    );

    // State, request latch, latency counter and read-data capture registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            req_q   <= '0;
            lat_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            lat_q   <= lat_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and output decode; RAM strobes only in ISSUE, responses only in RESP
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        lat_d       = lat_q;
        rdata_d     = rdata_q;
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;
        if_rvalid   = 1'b0;
        if_rdata    = '0;
        ls_done     = 1'b0;
        ls_rdata    = '0;
        ReadEnable  = 1'b0;
        WriteEnable = 1'b0;
        ReadAddr    = '0;
        WriteAddr   = '0;
        WriteMask   = '0;
        WriteData   = '0;

        case (state_q)
            ARB_IDLE, ARB_RESP: begin
                if (state_q == ARB_RESP) begin
                    if_rvalid = ~req_q.is_ls;
                    ls_done   = req_q.is_ls;
                    if (!req_q.is_ls) begin
                        if_rdata = req_q.addr[2] ? rdata_q[DATA_BUS-1:INST_BUS]
                                                 : rdata_q[INST_BUS-1:0];
                    end else if (!req_q.we) begin
                        ls_rdata = rdata_q;
                    end
                end
                state_d = ARB_IDLE;
                if (pick_if_c) begin
                    if_gnt      = 1'b1;
                    req_d.is_ls = 1'b0;
                    req_d.we    = 1'b0;
                    req_d.addr  = if_addr;
                    req_d.wdata = '0;
                    req_d.wmask = '0;
                    state_d     = ARB_ISSUE;
                end else if (pick_ls_c) begin
                    ls_gnt      = 1'b1;
                    req_d.is_ls = 1'b1;
                    req_d.we    = ls_we;
                    req_d.addr  = ls_addr;
                    req_d.wdata = ls_wdata;
                    req_d.wmask = ls_wmask;
                    state_d     = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                ReadEnable  = ~req_q.we;
                WriteEnable = req_q.we;
                ReadAddr    = req_q.addr;
                WriteAddr   = req_q.addr;
                WriteData   = req_q.wdata;
                WriteMask   = req_q.wmask;
                lat_d       = LAT_W'(MEM_LAT - 1);
                state_d     = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (lat_q == '0) begin
                    rdata_d = ReadData;
                    state_d = ARB_RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-timeline model.
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 3;
    localparam int STARVE_MAX = 2;
    localparam int M_RANDOM   = 0;
    localparam int M_HOLD     = 1;
    localparam int M_MANUAL   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [63:0] ls_addr;
    logic [63:0] ls_wdata;
    logic [63:0] ls_wmask;
    logic        ls_gnt;
    logic        ls_done;
    logic [63:0] ls_rdata;
    logic [63:0] ReadData;
    logic        ReadEnable;
    logic        WriteEnable;
    logic [63:0] ReadAddr;
    logic [63:0] WriteAddr;
    logic [63:0] WriteMask;
    logic [63:0] WriteData;

    mem_port_arbiter #(
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_wmask   (ls_wmask),
        .ls_gnt     (ls_gnt),
        .ls_done    (ls_done),
        .ls_rdata   (ls_rdata),
        .ReadData   (ReadData),
        .ReadEnable (ReadEnable),
        .WriteEnable(WriteEnable),
        .ReadAddr   (ReadAddr),
        .WriteAddr  (WriteAddr),
        .WriteMask  (WriteMask),
        .WriteData  (WriteData)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int mode   = M_MANUAL;
    bit if_granted;
    bit ls_granted;

    // Reference model: one outstanding transaction, age counted in cycles since its grant
    bit          m_busy;
    int          m_age;
    bit          m_ls;
    bit          m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [63:0] m_wmask;
    logic [63:0] m_rdata;
    int          m_starve;

    bit          e_if_gnt, e_ls_gnt, e_if_rvalid, e_ls_done, e_re, e_we;
    logic [31:0] e_if_rdata;
    logic [63:0] e_ls_rdata, e_raddr, e_waddr, e_wdata, e_wmask;

    int          gnt_cyc;
    int          done_cyc;
    int          we_cycles;
    logic [63:0] seen_rdata;
    bit          order_q[$];
    int          gcyc_q[$];
    bit          exp_order[6];
    bit          hit;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outputs(input string pfx);
        check_eq({pfx, ".if_gnt"},      64'(if_gnt),      64'(e_if_gnt));
        check_eq({pfx, ".ls_gnt"},      64'(ls_gnt),      64'(e_ls_gnt));
        check_eq({pfx, ".if_rvalid"},   64'(if_rvalid),   64'(e_if_rvalid));
        check_eq({pfx, ".if_rdata"},    64'(if_rdata),    64'(e_if_rdata));
        check_eq({pfx, ".ls_done"},     64'(ls_done),     64'(e_ls_done));
        check_eq({pfx, ".ls_rdata"},    ls_rdata,         e_ls_rdata);
        check_eq({pfx, ".ReadEnable"},  64'(ReadEnable),  64'(e_re));
        check_eq({pfx, ".WriteEnable"}, 64'(WriteEnable), 64'(e_we));
        check_eq({pfx, ".ReadAddr"},    ReadAddr,         e_raddr);
        check_eq({pfx, ".WriteAddr"},   WriteAddr,        e_waddr);
        check_eq({pfx, ".WriteData"},   WriteData,        e_wdata);
        check_eq({pfx, ".WriteMask"},   WriteMask,        e_wmask);
    endtask

    task automatic model_clear();
        m_busy     = 1'b0;
        m_age      = 0;
        m_starve   = 0;
        m_rdata    = '0;
        if_granted = 1'b0;
        ls_granted = 1'b0;
    endtask

    task automatic expect_zero();
        e_if_gnt = 0; e_ls_gnt = 0; e_if_rvalid = 0; e_ls_done = 0; e_re = 0; e_we = 0;
        e_if_rdata = '0; e_ls_rdata = '0; e_raddr = '0; e_waddr = '0; e_wdata = '0; e_wmask = '0;
    endtask

    task automatic compute_expected();
        bit resp, issue, arb;
        resp  = m_busy && (m_age == MEM_LAT + 2);
        issue = m_busy && (m_age == 1);
        arb   = !m_busy || resp;
        expect_zero();
        e_if_gnt = arb && if_req && (!ls_req || (m_starve == STARVE_MAX));
        e_ls_gnt = arb && ls_req && !e_if_gnt;
        if (issue) begin
            e_re    = !m_we;
            e_we    = m_we;
            e_raddr = m_addr;
            e_waddr = m_addr;
            e_wdata = m_wdata;
            e_wmask = m_wmask;
        end
        if (resp) begin
            e_if_rvalid = !m_ls;
            e_ls_done   = m_ls;
            if (!m_ls) e_if_rdata = m_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
            else if (!m_we) e_ls_rdata = m_rdata;
        end
    endtask

    task automatic drive();
        if (mode != M_MANUAL) ReadData = {$urandom, $urandom};
        if (!if_req || if_granted) begin
            if_granted = 1'b0;
            if (mode == M_MANUAL) begin
                if_req = 1'b0;
            end else begin
                if_req  = (mode == M_HOLD) ? 1'b1 : ($urandom_range(0, 99) < 45);
                if_addr = {$urandom, $urandom} & ~64'h3;
            end
        end
        if (!ls_req || ls_granted) begin
            ls_granted = 1'b0;
            if (mode == M_MANUAL) begin
                ls_req = 1'b0;
            end else begin
                ls_req   = (mode == M_HOLD) ? 1'b1 : ($urandom_range(0, 99) < 45);
                ls_we    = 1'($urandom_range(0, 1));
                ls_addr  = {$urandom, $urandom};
                ls_wdata = {$urandom, $urandom};
                ls_wmask = {$urandom, $urandom};
            end
        end
    endtask

    task automatic model_update();
        if (m_busy && (m_age == MEM_LAT + 1)) m_rdata = ReadData;
        if (!if_req || e_if_gnt) m_starve = 0;
        else if (e_ls_gnt && (m_starve < STARVE_MAX)) m_starve++;
        if (e_if_gnt || e_ls_gnt) begin
            m_busy  = 1'b1;
            m_age   = 1;
            m_ls    = e_ls_gnt;
            m_we    = e_ls_gnt ? ls_we : 1'b0;
            m_addr  = e_ls_gnt ? ls_addr : if_addr;
            m_wdata = e_ls_gnt ? ls_wdata : 64'h0;
            m_wmask = e_ls_gnt ? ls_wmask : 64'h0;
        end else if (m_busy) begin
            if (m_age == MEM_LAT + 2) m_busy = 1'b0;
            else m_age++;
        end
        if (e_if_gnt) if_granted = 1'b1;
        if (e_ls_gnt) ls_granted = 1'b1;
    endtask

    // One clock cycle: drive at negedge, check mid-low-phase, advance model at posedge
    task automatic step();
        drive();
        #1;
        compute_expected();
        check_outputs("cyc");
        if (if_gnt || ls_gnt) begin
            gnt_cyc = cyc;
            order_q.push_back(if_gnt);
            gcyc_q.push_back(cyc);
        end
        if (WriteEnable) we_cycles++;
        if (if_rvalid) begin done_cyc = cyc; seen_rdata = 64'(if_rdata); end
        if (ls_done)   begin done_cyc = cyc; seen_rdata = ls_rdata; end
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
    endtask

    task automatic reset_now();
        rst = 1'b0;
        #1;
        expect_zero();
        check_outputs("rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
    endtask

    task automatic clear_obs();
        gnt_cyc    = -100;
        done_cyc   = -1;
        we_cycles  = 0;
        seen_rdata = '1;
        order_q.delete();
        gcyc_q.delete();
    endtask

    initial begin
        exp_order = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        rst = 1'b0;
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0; ReadData = '0;
        model_clear();
        @(negedge clk);
        reset_now();
        if_req = 1'b0;
        ls_req = 1'b0;

        // Fetch of the upper word
        clear_obs();
        mode = M_MANUAL;
        if_addr  = 64'h8000_0004;
        ReadData = 64'h1111_2222_3333_4444;
        if_req   = 1'b1;
        repeat (MEM_LAT + 4) step();
        check_eq("fetch_latency", 64'(done_cyc - gnt_cyc), 64'(MEM_LAT + 2));
        check_eq("fetch_rdata", seen_rdata, 64'h1111_2222);

        // Store: single write strobe, zero read data at completion
        clear_obs();
        ls_we    = 1'b1;
        ls_addr  = 64'h100;
        ls_wdata = 64'hDEAD_BEEF;
        ls_wmask = 64'hFFFF_FFFF;
        ReadData = 64'hA5A5_5A5A_C3C3_3C3C;
        ls_req   = 1'b1;
        repeat (MEM_LAT + 4) step();
        check_eq("store_latency", 64'(done_cyc - gnt_cyc), 64'(MEM_LAT + 2));
        check_eq("store_we_cycles", 64'(we_cycles), 64'd1);
        check_eq("store_rdata", seen_rdata, 64'h0);

        // Load and fetch collide: load first, fetch granted in the load's response cycle
        clear_obs();
        ls_we    = 1'b0;
        ls_addr  = 64'h208;
        if_addr  = 64'h40;
        ReadData = {$urandom, $urandom};
        if_req   = 1'b1;
        ls_req   = 1'b1;
        repeat (2 * (MEM_LAT + 2) + 2) step();
        check_eq("collide_grants", 64'(order_q.size()), 64'd2);
        if (order_q.size() >= 2) begin
            check_eq("collide_first_is_ls", 64'(order_q[0]), 64'd0);
            check_eq("collide_second_is_if", 64'(order_q[1]), 64'd1);
            check_eq("collide_gap", 64'(gcyc_q[1] - gcyc_q[0]), 64'(MEM_LAT + 2));
        end

        // Both requesters held high: fetch forced through every STARVE_MAX LSU wins
        reset_now();
        clear_obs();
        mode = M_HOLD;
        for (int i = 0; i < 200 && order_q.size() < 6; i++) step();
        check_eq("starve_grants", 64'(order_q.size() >= 6), 64'd1);
        if (order_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) check_eq($sformatf("starve_order%0d", i), 64'(order_q[i]), 64'(exp_order[i]));
        end

        // Random traffic, then a reset landing in the latency wait
        mode = M_RANDOM;
        repeat (300) step();
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (m_busy && (m_age >= 2) && (m_age <= MEM_LAT + 1)) hit = 1'b1;
            else step();
        end
        check_eq("reset_in_wait_reached", 64'(hit), 64'd1);
        if (hit) reset_now();
        repeat (300) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
